ax_btb_banked: RTL and testbench

Parametrised successor to the single-configuration ap.branch target buffer. The bank count, port counts, tag/target widths and conflict-queue depth are all parameters. Each entry carries a saturating confidence counter, so a hit is reported only after a target has repeated. Fetch reads the block with one-cycle latency, IntEx branch results write it, and a clear FSM sweeps the array after reset and on flush.

---
 rtl/ax_btb_banked_pkg.sv | 24 ++
 rtl/ax_btb_banked_conflict_queue.sv | 90 +++++++++
 rtl/ax_btb_banked.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_ax_btb_banked.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ax_btb_banked_pkg.sv
// Shared fetch-unit types for the banked branch target buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding and the index/bank path widths derived from
// the entry and bank counts. The entry and queue-entry layouts depend on
// per-instance widths, so the top declares them locally from these helpers.
package FetchUnitTypes;

    typedef enum logic {
        AX_BTB_CLEAR = 1'b0,
        AX_BTB_IDLE  = 1'b1
    } ax_btb_state_e;

    // Width of the full entry index (bank bits plus row bits).
    function automatic int ax_btb_index_path(input int entry_num);
        return $clog2(entry_num);
    endfunction

    // Width of the bank select taken from the low index bits.
    function automatic int ax_btb_bank_path(input int bank_num);
        return $clog2(bank_num);
    endfunction

endpackage

// File: rtl/ax_btb_banked_conflict_queue.sv
// Conflict queue: FIFO accepting several pushes per cycle and one pop.
// Latency: a pushed entry is visible at the head from the next cycle.
// Backpressure: none upstream; pushes that do not fit are dropped and counted.
// Ports: clk/rst_n, clr (synchronous empty), push_vld/push_dat per pusher,
//        pop, head_dat, empty, full (registered), drop_cnt (drops this cycle).
module ax_btb_conflict_queue #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 4,
    parameter int PUSH_NUM = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic [PUSH_NUM-1:0]           push_vld,
    input  logic [DATA_W-1:0]             push_dat [PUSH_NUM],
    input  logic                          pop,
    output logic [DATA_W-1:0]             head_dat,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(PUSH_NUM+1)-1:0] drop_cnt
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              full_q, full_d;

    // Explicit wrap so non-power-of-two depths still cycle modulo DEPTH.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (cnt_q == '0);
    assign full     = full_q;
    assign head_dat = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        drop_cnt = '0;
        // Pop first so a full queue can accept a push in the same cycle.
        if (pop && !empty) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
            cnt_d    = cnt_q - 1'b1;
        end
        for (int i = 0; i < PUSH_NUM; i++) begin
            if (push_vld[i]) begin
                if (cnt_d < CNT_W'(DEPTH)) begin
                    mem_d[wr_ptr_d] = push_dat[i];
                    wr_ptr_d        = ptr_inc(wr_ptr_d);
                    cnt_d           = cnt_d + 1'b1;
                end else begin
                    drop_cnt = drop_cnt + 1'b1;
                end
            end
        end
        if (clr) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end
        full_d = (cnt_d == CNT_W'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
        end
    end

    // Payload storage needs no reset: occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/ax_btb_banked.sv
// Banked branch target buffer with per-entry confidence and a bank-conflict queue.
// Latency: lookups registered, 1 cycle; writes land at the next edge (queued ones later).
// Backpressure: none; conflict losers are queued, overflow is dropped with dropPulse.
// Ports: clk, rst (async active-low), flushReq; rdPC/rdHit/rdTarget per read port;
//        wrValid/wrPC/wrTarget per write port; busy (clear sweep), queueFull, dropPulse.
module ax_btb_banked
    import FetchUnitTypes::*;
#(
    parameter int ENTRY_NUM    = 256,
    parameter int BANK_NUM     = 4,
    parameter int READ_NUM     = 2,
    parameter int WRITE_NUM    = 2,
    parameter int PC_WIDTH     = 32,
    parameter int TAG_WIDTH    = 8,
    parameter int TARGET_WIDTH = 16,
    parameter int QUEUE_DEPTH  = 4,
    parameter int CONF_BITS    = 2,
    parameter int CONF_THRESH  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flushReq,
    input  logic [PC_WIDTH-1:0] rdPC     [READ_NUM],
    output logic                rdHit    [READ_NUM],
    output logic [PC_WIDTH-1:0] rdTarget [READ_NUM],
    input  logic                wrValid  [WRITE_NUM],
    input  logic [PC_WIDTH-1:0] wrPC     [WRITE_NUM],
    input  logic [PC_WIDTH-1:0] wrTarget [WRITE_NUM],
    output logic                busy,
    output logic                queueFull,
    output logic                dropPulse
);
    localparam int IDX_W   = ax_btb_index_path(ENTRY_NUM);
    localparam int BANK_W  = ax_btb_bank_path(BANK_NUM);
    localparam int ROW_NUM = ENTRY_NUM / BANK_NUM;
    localparam int ROW_W   = IDX_W - BANK_W;
    localparam int DROP_W  = $clog2(WRITE_NUM + 1);

    typedef struct packed {
        logic                    valid;
        logic [TAG_WIDTH-1:0]    tag;
        logic [TARGET_WIDTH-1:0] target;
        logic [CONF_BITS-1:0]    conf;
    } ax_btb_entry_t;

    typedef struct packed {
        logic [IDX_W-1:0]        index;
        logic [TAG_WIDTH-1:0]    tag;
        logic [TARGET_WIDTH-1:0] target;
    } ax_btb_queue_entry_t;

    localparam int QW = $bits(ax_btb_queue_entry_t);

    function automatic logic [IDX_W-1:0] pc_index(input logic [PC_WIDTH-1:0] pc);
        return pc[IDX_W+1:2];
    endfunction

    function automatic logic [TAG_WIDTH-1:0] pc_tag(input logic [PC_WIDTH-1:0] pc);
        return pc[IDX_W+TAG_WIDTH+1:IDX_W+2];
    endfunction

    // A repeat of the same tag/target strengthens the entry; anything else
    // retrains it from scratch so a fresh target must repeat before it hits.
    function automatic ax_btb_entry_t entry_update(input ax_btb_entry_t          cur,
                                                   input logic [TAG_WIDTH-1:0]    tag,
                                                   input logic [TARGET_WIDTH-1:0] tgt);
        ax_btb_entry_t nxt;
        nxt = cur;
        if (cur.valid && (cur.tag == tag) && (cur.target == tgt)) begin
            if (cur.conf != {CONF_BITS{1'b1}}) begin
                nxt.conf = cur.conf + 1'b1;
            end
        end else begin
            nxt.valid  = 1'b1;
            nxt.tag    = tag;
            nxt.target = tgt;
            nxt.conf   = CONF_BITS'(1);
        end
        return nxt;
    endfunction

    ax_btb_state_e state_q, state_d;
    logic [ROW_W-1:0] clr_cnt_q, clr_cnt_d;

    ax_btb_entry_t       entry_q [BANK_NUM][ROW_NUM];
    logic [BANK_NUM-1:0] bank_we;
    logic [ROW_W-1:0]    bank_row    [BANK_NUM];
    ax_btb_entry_t       bank_wr_dat [BANK_NUM];

    logic [IDX_W-1:0]        wr_idx  [WRITE_NUM];
    logic [BANK_W-1:0]       wr_bank [WRITE_NUM];
    logic [ROW_W-1:0]        wr_row  [WRITE_NUM];
    logic [TAG_WIDTH-1:0]    wr_tag  [WRITE_NUM];
    logic [TARGET_WIDTH-1:0] wr_tgt  [WRITE_NUM];
    logic                    any_idle;

    logic [WRITE_NUM-1:0] push_vld;
    logic [QW-1:0]        push_dat [WRITE_NUM];
    logic                 q_pop, q_clr, q_empty, q_full;
    logic [QW-1:0]        q_head_dat;
    ax_btb_queue_entry_t  q_head;
    logic [BANK_W-1:0]    head_bank;
    logic [ROW_W-1:0]     head_row;
    logic [DROP_W-1:0]    q_drop_cnt;

    logic [IDX_W-1:0]    rd_idx [READ_NUM];
    ax_btb_entry_t       rd_ent [READ_NUM];
    logic                rd_hit_q    [READ_NUM];
    logic                rd_hit_d    [READ_NUM];
    logic [PC_WIDTH-1:0] rd_target_q [READ_NUM];
    logic [PC_WIDTH-1:0] rd_target_d [READ_NUM];
    logic                drop_pulse_q, drop_pulse_d;

    // Address bits outside the index/tag/target fields are deliberately ignored.
    logic unused_addr_bits;

    always_comb begin
        unused_addr_bits = 1'b0;
        for (int p = 0; p < WRITE_NUM; p++) begin
            unused_addr_bits = unused_addr_bits ^ (^wrPC[p]) ^ (^wrTarget[p]);
        end
        for (int r = 0; r < READ_NUM; r++) begin
            unused_addr_bits = unused_addr_bits ^ (^rdPC[r]);
        end
    end

    always_comb begin
        for (int p = 0; p < WRITE_NUM; p++) begin
            wr_idx[p]  = pc_index(wrPC[p]);
            wr_bank[p] = wr_idx[p][BANK_W-1:0];
            wr_row[p]  = wr_idx[p][IDX_W-1:BANK_W];
            wr_tag[p]  = pc_tag(wrPC[p]);
            wr_tgt[p]  = wrTarget[p][TARGET_WIDTH+1:2];
        end
    end

    assign q_head    = ax_btb_queue_entry_t'(q_head_dat);
    assign head_bank = q_head.index[BANK_W-1:0];
    assign head_row  = q_head.index[IDX_W-1:BANK_W];

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        bank_we   = '0;
        for (int b = 0; b < BANK_NUM; b++) begin
            bank_row[b]    = '0;
            bank_wr_dat[b] = '0;
        end
        push_vld = '0;
        for (int p = 0; p < WRITE_NUM; p++) begin
            push_dat[p] = '0;
        end
        q_pop    = 1'b0;
        q_clr    = 1'b0;
        any_idle = 1'b0;

        case (state_q)
            AX_BTB_CLEAR: begin
                // Writes arriving during the sweep are discarded silently.
                q_clr = 1'b1;
                for (int b = 0; b < BANK_NUM; b++) begin
                    bank_we[b]     = 1'b1;
                    bank_row[b]    = clr_cnt_q;
                    bank_wr_dat[b] = '0;
                end
                if (clr_cnt_q == ROW_W'(ROW_NUM - 1)) begin
                    state_d   = AX_BTB_IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            AX_BTB_IDLE: begin
                // Ascending scan: the first port to claim a bank wins it.
                for (int p = 0; p < WRITE_NUM; p++) begin
                    if (wrValid[p]) begin
                        if (!bank_we[wr_bank[p]]) begin
                            bank_we[wr_bank[p]]     = 1'b1;
                            bank_row[wr_bank[p]]    = wr_row[p];
                            bank_wr_dat[wr_bank[p]] = entry_update(
                                entry_q[wr_bank[p]][wr_row[p]], wr_tag[p], wr_tgt[p]);
                        end else begin
                            push_vld[p] = 1'b1;
                            push_dat[p] = {wr_idx[p], wr_tag[p], wr_tgt[p]};
                        end
                    end else begin
                        any_idle = 1'b1;
                    end
                end
                // The head borrows an idle port's slot; a direct write to its
                // bank keeps priority and the head simply waits.
                if (!q_empty && any_idle && !bank_we[head_bank]) begin
                    q_pop                  = 1'b1;
                    bank_we[head_bank]     = 1'b1;
                    bank_row[head_bank]    = head_row;
                    bank_wr_dat[head_bank] = entry_update(
                        entry_q[head_bank][head_row], q_head.tag, q_head.target);
                end
                if (flushReq) begin
                    state_d   = AX_BTB_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            default: begin
                state_d   = AX_BTB_CLEAR;
                clr_cnt_d = '0;
            end
        endcase
    end

    ax_btb_conflict_queue #(
        .DATA_W   (QW),
        .DEPTH    (QUEUE_DEPTH),
        .PUSH_NUM (WRITE_NUM)
    ) u_conflict_queue (
        .clk      (clk),
        .rst_n    (rst),
        .clr      (q_clr),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop      (q_pop),
        .head_dat (q_head_dat),
        .empty    (q_empty),
        .full     (q_full),
        .drop_cnt (q_drop_cnt)
    );

    assign drop_pulse_d = (q_drop_cnt != '0);

    // Lookups see the array before this cycle's writes land.
    always_comb begin
        for (int r = 0; r < READ_NUM; r++) begin
            rd_idx[r]      = pc_index(rdPC[r]);
            rd_ent[r]      = entry_q[rd_idx[r][BANK_W-1:0]][rd_idx[r][IDX_W-1:BANK_W]];
            rd_hit_d[r]    = (state_q == AX_BTB_IDLE) && rd_ent[r].valid &&
                             (rd_ent[r].tag == pc_tag(rdPC[r])) &&
                             (rd_ent[r].conf >= CONF_BITS'(CONF_THRESH));
            rd_target_d[r] = {rdPC[r][PC_WIDTH-1:TARGET_WIDTH+2], rd_ent[r].target, 2'b00};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= AX_BTB_CLEAR;
            clr_cnt_q    <= '0;
            drop_pulse_q <= 1'b0;
            for (int r = 0; r < READ_NUM; r++) begin
                rd_hit_q[r]    <= 1'b0;
                rd_target_q[r] <= '0;
            end
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            drop_pulse_q <= drop_pulse_d;
            for (int r = 0; r < READ_NUM; r++) begin
                rd_hit_q[r]    <= rd_hit_d[r];
                rd_target_q[r] <= rd_target_d[r];
            end
        end
    end

    // Entry storage is not reset; the clear sweep invalidates it instead.
    always_ff @(posedge clk) begin
        for (int b = 0; b < BANK_NUM; b++) begin
            if (bank_we[b]) begin
                entry_q[b][bank_row[b]] <= bank_wr_dat[b];
            end
        end
    end

    assign busy      = (state_q == AX_BTB_CLEAR);
    assign queueFull = q_full;
    assign dropPulse = drop_pulse_q;

    always_comb begin
        for (int r = 0; r < READ_NUM; r++) begin
            rdHit[r]    = rd_hit_q[r];
            rdTarget[r] = rd_target_q[r];
        end
    end

endmodule

// File: tb/tb_ax_btb_banked.sv
// Directed bench for ax_btb_banked with default parameters.
// Inputs driven and outputs sampled on the falling edge.
// Expected values are hand-derived from the address field layout.
module tb_ax_btb_banked;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_req;
    logic [31:0] rd_pc     [2];
    logic        rd_hit    [2];
    logic [31:0] rd_target [2];
    logic        wr_valid  [2];
    logic [31:0] wr_pc     [2];
    logic [31:0] wr_target [2];
    logic        busy;
    logic        queue_full;
    logic        drop_pulse;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc;
    logic hit_seen;

    always #5 clk = ~clk;

    ax_btb_banked dut (
        .clk       (clk),
        .rst       (rst),
        .flushReq  (flush_req),
        .rdPC      (rd_pc),
        .rdHit     (rd_hit),
        .rdTarget  (rd_target),
        .wrValid   (wr_valid),
        .wrPC      (wr_pc),
        .wrTarget  (wr_target),
        .busy      (busy),
        .queueFull (queue_full),
        .dropPulse (drop_pulse)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_writes();
        wr_valid[0] = 1'b0;
        wr_valid[1] = 1'b0;
    endtask

    task automatic drive_wr(input int p, input logic [31:0] pc, input logic [31:0] tgt);
        wr_valid[p]  = 1'b1;
        wr_pc[p]     = pc;
        wr_target[p] = tgt;
    endtask

    // Counts busy cycles (bounded), holding flushReq high for the first
    // hold_flush cycles, and notes any hit reported during the sweep.
    task automatic wait_sweep(input int hold_flush, output int cycles);
        cycles   = 0;
        hit_seen = 1'b0;
        while (busy && cycles < 200) begin
            flush_req = (cycles < hold_flush);
            @(negedge clk);
            cycles++;
            if (rd_hit[0] || rd_hit[1]) hit_seen = 1'b1;
        end
        flush_req = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        flush_req = 1'b0;
        rd_pc[0]  = 32'h0;
        rd_pc[1]  = 32'h0;
        for (int p = 0; p < 2; p++) begin
            wr_valid[p]  = 1'b0;
            wr_pc[p]     = 32'h0;
            wr_target[p] = 32'h0;
        end

        // Reset state
        repeat (3) step();
        check("rst_busy", busy, 1);
        check("rst_qfull", queue_full, 0);
        check("rst_drop", drop_pulse, 0);
        check("rst_hit", rd_hit[0], 0);
        check("rst_target", rd_target[0], 32'h0);

        // Sweep after reset release
        rst      = 1'b1;
        rd_pc[0] = 32'h1000;
        rd_pc[1] = 32'h2004;
        wait_sweep(0, cyc);
        check("init_sweep_len", cyc, 64);
        check("init_sweep_nohit", hit_seen, 0);

        // Confidence training: hit only after the target repeats
        drive_wr(0, 32'h1000, 32'h2000);
        rd_pc[0] = 32'h1000;
        step();
        check("train_before", rd_hit[0], 0);
        step();
        check("train_conf1", rd_hit[0], 0);
        idle_writes();
        step();
        check("train_hit", rd_hit[0], 1);
        check("train_target", rd_target[0], 32'h2000);

        // Same-bank conflict: port 1 queued, drained next idle cycle
        drive_wr(0, 32'h1000, 32'h2000);
        drive_wr(1, 32'h1040, 32'h2400);
        rd_pc[1] = 32'h1040;
        step();
        check("conf_qfull", queue_full, 0);
        check("conf_drop", drop_pulse, 0);
        check("conf_rd_pre", rd_hit[1], 0);
        idle_writes();
        step();
        check("conf_port0_hit", rd_hit[0], 1);
        drive_wr(0, 32'h1040, 32'h2400);
        step();
        check("conf_queued_conf1", rd_hit[1], 0);
        idle_writes();
        step();
        check("conf_queued_hit", rd_hit[1], 1);
        check("conf_queued_target", rd_target[1], 32'h2400);

        // Queue overflow: five conflicting pairs into a 4-deep queue
        for (int i = 0; i < 5; i++) begin
            drive_wr(0, 32'h2004 + 32'(i) * 32'h10, 32'h5000);
            drive_wr(1, 32'h2084 + 32'(i) * 32'h10, 32'h4000 + 32'(i) * 32'h100);
            step();
            check($sformatf("ovf_qfull_%0d", i), queue_full, (i >= 3) ? 1 : 0);
            check($sformatf("ovf_drop_%0d", i), drop_pulse, (i == 4) ? 1 : 0);
        end
        idle_writes();
        step();
        check("ovf_drop_clear", drop_pulse, 0);
        check("ovf_qfull_clear", queue_full, 0);
        repeat (4) step();
        drive_wr(0, 32'h20C4, 32'h4400);
        step();
        drive_wr(0, 32'h20B4, 32'h4300);
        rd_pc[0] = 32'h20C4;
        step();
        check("ovf_dropped_absent", rd_hit[0], 0);
        idle_writes();
        rd_pc[0] = 32'h20B4;
        step();
        check("ovf_last_queued_hit", rd_hit[0], 1);
        check("ovf_last_queued_tgt", rd_target[0], 32'h4300);

        // Retarget a trained entry
        rd_pc[0] = 32'h1000;
        drive_wr(0, 32'h1000, 32'h3000);
        step();
        check("retgt_pre_hit", rd_hit[0], 1);
        check("retgt_pre_target", rd_target[0], 32'h2000);
        idle_writes();
        step();
        check("retgt_conf1", rd_hit[0], 0);
        drive_wr(0, 32'h1000, 32'h3000);
        step();
        idle_writes();
        step();
        check("retgt_hit", rd_hit[0], 1);
        check("retgt_target", rd_target[0], 32'h3000);

        // Flush with a queued write pending; flushReq held during the sweep
        drive_wr(0, 32'h1000, 32'h3000);
        drive_wr(1, 32'h1040, 32'h2400);
        flush_req = 1'b1;
        step();
        check("flush_busy", busy, 1);
        idle_writes();
        wait_sweep(10, cyc);
        check("flush_sweep_len", cyc, 64);
        check("flush_nohit", hit_seen, 0);
        rd_pc[0] = 32'h1000;
        rd_pc[1] = 32'h20B4;
        drive_wr(0, 32'h1040, 32'h2400);
        step();
        check("flush_miss_a", rd_hit[0], 0);
        check("flush_miss_b", rd_hit[1], 0);
        idle_writes();
        step();
        rd_pc[0] = 32'h1040;
        step();
        check("flush_queue_emptied", rd_hit[0], 0);

        // Reset in the middle of a sweep restarts it from row 0
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        repeat (20) step();
        rst = 1'b0;
        step();
        check("midrst_busy", busy, 1);
        check("midrst_qfull", queue_full, 0);
        check("midrst_drop", drop_pulse, 0);
        check("midrst_target", rd_target[0], 32'h0);
        rst = 1'b1;
        wait_sweep(0, cyc);
        check("midrst_sweep_len", cyc, 64);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
